// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, redirect and data-memory stall control for a 5-stage pipeline.
// Define PIPELINE_CTRL_STALL_CNT_EN to add the saturating 16-bit stall_cnt output.
module pipeline_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_memread,
    input  logic       ex_redirect,
    input  logic       dmem_req,
    input  logic       dmem_ack,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_write,
    output logic       exmem_write,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       memwb_bubble,
    output logic       err,
    output logic [1:0] state_o
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, ERROR = 2'd2} state_t;
    state_t     state;
    logic [7:0] wait_cnt;
    logic       err_st, freeze, redirect, load_use, halt;
    // Hazard terms are gated by rst_n so outputs read as normal RUN while held in reset.
    assign err_st   = state == ERROR;
    assign freeze   = rst_n && !err_st && dmem_req && !dmem_ack;
    assign redirect = rst_n && ex_redirect;
    assign load_use = rst_n && ex_memread && ex_rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign halt         = err_st || freeze;
    assign pc_write     = !halt && (redirect || !load_use);
    assign ifid_write   = !halt && (redirect || !load_use);
    assign idex_write   = !halt;
    assign exmem_write  = !halt;
    assign ifid_flush   = !halt && redirect;
    assign idex_flush   = !halt && (redirect || load_use);
    assign memwb_bubble = halt;
    assign err          = err_st;
    assign state_o      = state;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                RUN: if (freeze) begin
                    state    <= MEMWAIT;
                    wait_cnt <= 8'd0;
                end
                MEMWAIT: if (dmem_ack) state <= RUN;
                    else if (wait_cnt == 8'(TIMEOUT - 1)) state <= ERROR;
                    else wait_cnt <= wait_cnt + 8'd1;
                ERROR: state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt <= 16'd0;
        else if (!pc_write && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl with TIMEOUT=4.
module tb_pipeline_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect, dmem_req, dmem_ack;
    logic       pc_write, ifid_write, idex_write, exmem_write;
    logic       ifid_flush, idex_flush, memwb_bubble, err;
    logic [1:0] state_o;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    logic [7:0] outs;
    int tests = 0;
    int fails = 0;
    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble, err}
    localparam logic [7:0] NORM = 8'b1111_0000;
    localparam logic [7:0] LU   = 8'b0011_0100;
    localparam logic [7:0] RED  = 8'b1111_1100;
    localparam logic [7:0] FRZ  = 8'b0000_0010;
    localparam logic [7:0] ERR  = 8'b0000_0011;

    pipeline_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .memwb_bubble(memwb_bubble), .err(err), .state_o(state_o)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    assign outs = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble, err};
    always #5 clk = ~clk;

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memread = 1'b0;
        ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lu(input logic [4:0] rd);
        ex_memread = 1'b1; ex_rd = rd; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        dmem_req = 1'b1; ex_redirect = 1'b1;
        #1;
        tests++; if (outs !== NORM) begin fails++; $display("FAIL reset_outs got %b want %b", outs, NORM); end
        tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state_o); end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if (outs !== NORM) begin fails++; $display("FAIL idle_outs got %b want %b", outs, NORM); end
    endtask

    task automatic test_load_use();
        set_lu(5'd5);
        #1;
        tests++; if (outs !== LU) begin fails++; $display("FAIL load_use_rs1 got %b want %b", outs, LU); end
        tick();
        ex_memread = 1'b0; ex_rd = 5'd0;
        #1;
        tests++; if (outs !== NORM) begin fails++; $display("FAIL load_use_after got %b want %b", outs, NORM); end
        idle();
        ex_memread = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1;
        tests++; if (outs !== LU) begin fails++; $display("FAIL load_use_rs2 got %b want %b", outs, LU); end
        id_use_rs2 = 1'b0;
        #1;
        tests++; if (outs !== NORM) begin fails++; $display("FAIL load_use_unused got %b want %b", outs, NORM); end
        idle();
        tick();
    endtask

    task automatic test_rd_zero_redirect();
        set_lu(5'd0);
        id_rs1 = 5'd0;
        #1;
        tests++; if (outs !== NORM) begin fails++; $display("FAIL rd_zero got %b want %b", outs, NORM); end
        ex_redirect = 1'b1;
        #1;
        tests++; if (outs !== RED) begin fails++; $display("FAIL redirect got %b want %b", outs, RED); end
        set_lu(5'd5);
        #1;
        tests++; if (outs !== RED) begin fails++; $display("FAIL redirect_over_lu got %b want %b", outs, RED); end
        idle();
        tick();
    endtask

    task automatic test_memwait();
        dmem_req = 1'b1; dmem_ack = 1'b1;
        #1;
        tests++; if (outs !== NORM) begin fails++; $display("FAIL ack_same_cycle got %b want %b", outs, NORM); end
        tick();
        tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL ack_same_state got %0d want 0", state_o); end
        dmem_ack = 1'b0; ex_redirect = 1'b1;
        set_lu(5'd5);
        #1;
        tests++; if (outs !== FRZ) begin fails++; $display("FAIL freeze_prio got %b want %b", outs, FRZ); end
        idle();
        dmem_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++; if (state_o !== 2'd1 || outs !== FRZ) begin fails++; $display("FAIL memwait_%0d got %0d/%b want 1/%b", i, state_o, outs, FRZ); end
        end
        tick();
        dmem_ack = 1'b1;
        #1;
        tests++; if (state_o !== 2'd1 || outs !== NORM) begin fails++; $display("FAIL memwait_ack got %0d/%b want 1/%b", state_o, outs, NORM); end
        tick();
        idle();
        #1;
        tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL memwait_exit got %0d want 0", state_o); end
    endtask

    task automatic test_timeout();
        dmem_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL timeout_wait_%0d got %0d want 1", i, state_o); end
        end
        tick();
        tests++; if (state_o !== 2'd2 || outs !== ERR) begin fails++; $display("FAIL timeout_err got %0d/%b want 2/%b", state_o, outs, ERR); end
        dmem_ack = 1'b1; ex_redirect = 1'b1;
        tick();
        tick();
        tests++; if (state_o !== 2'd2 || outs !== ERR) begin fails++; $display("FAIL err_sticky got %0d/%b want 2/%b", state_o, outs, ERR); end
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (state_o !== 2'd0 || err !== 1'b0) begin fails++; $display("FAIL err_reset got %0d/%b want 0/0", state_o, err); end
        rst_n = 1'b1;
        tick();
        tests++; if (state_o !== 2'd0 || outs !== NORM) begin fails++; $display("FAIL err_after_reset got %0d/%b want 0/%b", state_o, outs, NORM); end
    endtask

    task automatic test_async_reset_memwait();
        dmem_req = 1'b1;
        tick();
        tick();
        tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL pre_async got %0d want 1", state_o); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (state_o !== 2'd0 || err !== 1'b0 || outs !== NORM) begin fails++; $display("FAIL async_reset got %0d/%b want 0/%b", state_o, outs, NORM); end
        idle();
        rst_n = 1'b1;
        tick();
        tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL async_after got %0d want 0", state_o); end
    endtask

`ifdef PIPELINE_CTRL_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_n = 1'b0;
        #1;
        tests++; if (stall_cnt !== 16'd0) begin fails++; $display("FAIL stall_cnt_reset got %0d want 0", stall_cnt); end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            set_lu(5'd5);
            tick();
            idle();
        end
        dmem_req = 1'b1;
        tick(); tick(); tick();
        dmem_ack = 1'b1;
        tick();
        idle();
        #1;
        tests++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
        force dut.stall_cnt = 16'hFFFF;
        #1;
        release dut.stall_cnt;
        dmem_req = 1'b1;
        tick(); tick();
        tests++; if (stall_cnt !== 16'hFFFF) begin fails++; $display("FAIL stall_cnt_sat got %h want ffff", stall_cnt); end
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero_redirect();
        test_memwait();
        test_timeout();
        test_async_reset_memwait();
`ifdef PIPELINE_CTRL_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
